// File: rtl/hand_tracker.sv
// hand_tracker: accumulates per-frame palm/finger marker statistics for two
// gloves, computes palm centroids with one shared serial divider at frame end,
// and debounces the per-glove grab state. All outputs move together on update.
module hand_tracker #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int MIN_PIX  = 64,
  parameter int FING_MAX = 32,
  parameter int DEBOUNCE = 3     // debounce counter is 2 bits: 1..4 supported
) (
  input  logic        clock_65mhz,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        vsync,
  input  logic        palm1,
  input  logic        palm2,
  input  logic        fing1,
  input  logic        fing2,
  output logic [10:0] userhand1x,
  output logic [9:0]  userhand1y,
  output logic [10:0] userhand2x,
  output logic [9:0]  userhand2y,
  output logic        usergrab1,
  output logic        usergrab2,
  output logic        seen1,
  output logic        seen2,
  output logic        update
);

  localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM     = 10'(V_ACTIVE);
  localparam logic [19:0] MIN_CNT   = 20'(MIN_PIX);
  localparam logic [19:0] FING_LIM  = 20'(FING_MAX);
  localparam logic [10:0] X_CLAMP   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_CLAMP   = 10'(V_ACTIVE - 1);
  localparam logic [1:0]  DB_LAST   = 2'(DEBOUNCE - 1);
  localparam logic [3:0]  LAST_ITER = 4'd11;

  typedef enum logic [1:0] {IDLE, DIV, DECIDE} state_t;

  state_t state, state_d;

  // Live accumulators (current frame) and their frame-end snapshots.
  logic [19:0] pcnt1, pcnt2, fcnt1, fcnt2;
  logic [29:0] sx1, sy1, sx2, sy2;
  logic [19:0] s_pcnt1, s_pcnt2, s_fcnt1, s_fcnt2;
  logic [29:0] s_sx1, s_sy1, s_sx2, s_sy2;

  logic        pix_active, frame_start;
  logic [29:0] hx, vy;
  logic        vsync_q, frame_end;

  // Divider job sequencing and datapath.
  logic [1:0]  job, first_job, next_job;
  logic        first_ok, next_ok;
  logic [3:0]  cnt;
  logic [19:0] rem, rem_next, divisor;
  logic [29:0] dividend;
  logic [10:0] dq, q_final;
  logic [9:0]  quo;
  logic [20:0] trial;
  logic        fits;
  logic [10:0] qx1, qy1, qx2, qy2;

  // Frame decision terms.
  logic        seen1_s, seen2_s, cand1, cand2;
  logic [1:0]  db1, db2;

  assign pix_active  = (hcount < H_LIM) && (vcount < V_LIM);
  assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);
  assign hx          = {19'd0, hcount};
  assign vy          = {20'd0, vcount};

  assign seen1_s = (s_pcnt1 >= MIN_CNT);
  assign seen2_s = (s_pcnt2 >= MIN_CNT);
  assign cand1   = seen1_s && (s_fcnt1 < FING_LIM);
  assign cand2   = seen2_s && (s_fcnt2 < FING_LIM);

  function automatic logic [10:0] clamp_x(input logic [10:0] q);
    return (q > X_CLAMP) ? X_CLAMP : q;
  endfunction

  function automatic logic [9:0] clamp_y(input logic [10:0] q);
    return (q > {1'b0, Y_CLAMP}) ? Y_CLAMP : q[9:0];
  endfunction

  // Per-pixel accumulation; frame start restarts the sums with pixel (0,0).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      pcnt1 <= '0; fcnt1 <= '0; sx1 <= '0; sy1 <= '0;
      pcnt2 <= '0; fcnt2 <= '0; sx2 <= '0; sy2 <= '0;
    end else if (frame_start) begin
      // hcount and vcount are both zero here, so the position sums clear.
      pcnt1 <= {19'd0, palm1}; fcnt1 <= {19'd0, fing1}; sx1 <= '0; sy1 <= '0;
      pcnt2 <= {19'd0, palm2}; fcnt2 <= {19'd0, fing2}; sx2 <= '0; sy2 <= '0;
    end else if (pix_active) begin
      pcnt1 <= pcnt1 + {19'd0, palm1};
      fcnt1 <= fcnt1 + {19'd0, fing1};
      pcnt2 <= pcnt2 + {19'd0, palm2};
      fcnt2 <= fcnt2 + {19'd0, fing2};
      if (palm1) begin
        sx1 <= sx1 + hx;
        sy1 <= sy1 + vy;
      end
      if (palm2) begin
        sx2 <= sx2 + hx;
        sy2 <= sy2 + vy;
      end
    end
  end

  // Registered vsync falling-edge detect: frame_end is a one-cycle pulse.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      vsync_q   <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      frame_end <= vsync_q & ~vsync;
    end
  end

  // Snapshot on an accepted frame end; a frame end outside IDLE is dropped.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      s_pcnt1 <= '0; s_fcnt1 <= '0; s_sx1 <= '0; s_sy1 <= '0;
      s_pcnt2 <= '0; s_fcnt2 <= '0; s_sx2 <= '0; s_sy2 <= '0;
    end else if (frame_end && (state == IDLE)) begin
      s_pcnt1 <= pcnt1; s_fcnt1 <= fcnt1; s_sx1 <= sx1; s_sy1 <= sy1;
      s_pcnt2 <= pcnt2; s_fcnt2 <= fcnt2; s_sx2 <= sx2; s_sy2 <= sy2;
    end
  end

  // FSM state register.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and job selection; jobs for a glove are skipped when its palm
  // count is below MIN_PIX, and with no job at all DIV takes zero cycles.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state;
    first_job = 2'd0;
    first_ok  = 1'b0;
    next_job  = job + 2'd1;
    next_ok   = 1'b0;
    if (pcnt1 >= MIN_CNT) begin
      first_job = 2'd0;
      first_ok  = 1'b1;
    end else if (pcnt2 >= MIN_CNT) begin
      first_job = 2'd2;
      first_ok  = 1'b1;
    end
    case (job)
      2'd0:    next_ok = 1'b1;     // glove 1 y follows glove 1 x
      2'd1:    next_ok = seen2_s;
      2'd2:    next_ok = 1'b1;     // glove 2 y follows glove 2 x
      default: next_ok = 1'b0;
    endcase
    case (state)
      IDLE:    if (frame_end) state_d = first_ok ? DIV : DECIDE;
      DIV:     if ((cnt == LAST_ITER) && !next_ok) state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider operand mux and one restoring step. The quotient never exceeds
  // 11 bits (a mean of coordinates), so the remainder starts at dividend>>11.
  always_comb begin
    dividend = s_sx1;
    divisor  = s_pcnt1;
    case (job)
      2'd1:    dividend = s_sy1;
      2'd2:    begin dividend = s_sx2; divisor = s_pcnt2; end
      2'd3:    begin dividend = s_sy2; divisor = s_pcnt2; end
      default: ;
    endcase
    trial    = {rem, dq[10]};
    fits     = (trial >= {1'b0, divisor});
    rem_next = fits ? 20'(trial - {1'b0, divisor}) : trial[19:0];
    q_final  = {quo, fits};
  end

  // Divider sequencing: per job one load cycle then 11 quotient-bit cycles.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      job <= '0; cnt <= '0; rem <= '0; dq <= '0; quo <= '0;
      qx1 <= '0; qy1 <= '0; qx2 <= '0; qy2 <= '0;
    end else if (state == IDLE) begin
      if (frame_end) begin
        job <= first_job;
        cnt <= '0;
      end
    end else if (state == DIV) begin
      if (cnt == 4'd0) begin
        rem <= {1'b0, dividend[29:11]};
        dq  <= dividend[10:0];
        quo <= '0;
        cnt <= 4'd1;
      end else begin
        rem <= rem_next;
        dq  <= {dq[9:0], 1'b0};
        quo <= {quo[8:0], fits};
        if (cnt == LAST_ITER) begin
          case (job)
            2'd0:    qx1 <= q_final;
            2'd1:    qy1 <= q_final;
            2'd2:    qx2 <= q_final;
            default: qy2 <= q_final;
          endcase
          job <= next_job;
          cnt <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  // Frame decision: positions, seen flags and debounced grab, all published
  // together with the one-cycle update strobe.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      userhand1x <= '0; userhand1y <= '0; userhand2x <= '0; userhand2y <= '0;
      usergrab1  <= 1'b0; usergrab2 <= 1'b0;
      seen1      <= 1'b0; seen2     <= 1'b0;
      update     <= 1'b0;
      db1        <= '0;   db2       <= '0;
    end else begin
      update <= (state == DECIDE);
      if (state == DECIDE) begin
        seen1 <= seen1_s;
        seen2 <= seen2_s;
        if (seen1_s) begin
          userhand1x <= clamp_x(qx1);
          userhand1y <= clamp_y(qy1);
        end
        if (seen2_s) begin
          userhand2x <= clamp_x(qx2);
          userhand2y <= clamp_y(qy2);
        end
        if (cand1 == usergrab1) begin
          db1 <= '0;
        end else if (db1 == DB_LAST) begin
          usergrab1 <= cand1;
          db1       <= '0;
        end else begin
          db1 <= db1 + 2'd1;
        end
        if (cand2 == usergrab2) begin
          db2 <= '0;
        end else if (db2 == DB_LAST) begin
          usergrab2 <= cand2;
          db2       <= '0;
        end else begin
          db2 <= db2 + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hand_tracker.sv
// tb_hand_tracker: table of compressed frames (only the interesting pixels are
// presented, each for one cycle) with hand-computed centroids, grab history and
// frame-end-to-update latency, plus sequences for a dropped frame end and a
// reset during division.
module tb_hand_tracker;

  logic        clock_65mhz = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        vsync, palm1, palm2, fing1, fing2;
  logic [10:0] userhand1x, userhand2x;
  logic [9:0]  userhand1y, userhand2y;
  logic        usergrab1, usergrab2, seen1, seen2, update;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_65mhz = ~clock_65mhz;

  hand_tracker dut (
    .clock_65mhz (clock_65mhz),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .vsync       (vsync),
    .palm1       (palm1),
    .palm2       (palm2),
    .fing1       (fing1),
    .fing2       (fing2),
    .userhand1x  (userhand1x),
    .userhand1y  (userhand1y),
    .userhand2x  (userhand2x),
    .userhand2y  (userhand2y),
    .usergrab1   (usergrab1),
    .usergrab2   (usergrab2),
    .seen1       (seen1),
    .seen2       (seen2),
    .update      (update)
  );

  // Glove rectangles (w=0: absent), finger pixel counts, out-of-range pixel
  // count, then expected outputs after this frame's update and its latency.
  typedef struct {
    int x1, y1, w1, h1, f1;
    int x2, y2, w2, h2, f2;
    int oob;
    int hx1, hy1, hx2, hy2;
    int g1, g2, s1, s2;
    int lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hcount = 11'd1100; vcount = 10'd0;
    palm1 = 1'b0; palm2 = 1'b0; fing1 = 1'b0; fing2 = 1'b0;
  endtask

  // Present one pixel for one clock cycle.
  task automatic pix(input int h, input int v, input logic p1, input logic p2,
                     input logic f1, input logic f2);
    hcount = 11'(h); vcount = 10'(v);
    palm1 = p1; palm2 = p2; fing1 = f1; fing2 = f2;
    @(posedge clock_65mhz); #1;
  endtask

  task automatic drive_frame(input vec_t v);
    pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int y = 0; y < v.h1; y++)
      for (int x = 0; x < v.w1; x++) pix(v.x1 + x, v.y1 + y, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int y = 0; y < v.h2; y++)
      for (int x = 0; x < v.w2; x++) pix(v.x2 + x, v.y2 + y, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < v.f1; i++) pix(600 + i, 600, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < v.f2; i++) pix(600 + i, 601, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < v.oob; i++) begin
      if (i % 2 == 0) pix(1030, 10, 1'b1, 1'b1, 1'b1, 1'b1);
      else            pix(10, 770, 1'b1, 1'b1, 1'b1, 1'b1);
    end
    idle_inputs();
    @(posedge clock_65mhz); #1;
  endtask

  // Drop vsync and count clock edges until update is seen (bounded).
  task automatic end_frame(output int lat, output int got);
    lat = 0; got = 0;
    vsync = 1'b0;
    for (int c = 1; c <= 200 && got == 0; c++) begin
      @(posedge clock_65mhz); #1;
      if (update) begin
        got = 1;
        lat = c;
      end
      if (c == 4) vsync = 1'b1;
    end
    vsync = 1'b1;
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int lat, input int got);
    check($sformatf("%s_update_seen", tag), got, 1);
    check($sformatf("%s_latency", tag), lat, v.lat);
    check($sformatf("%s_hand1x", tag), userhand1x, v.hx1);
    check($sformatf("%s_hand1y", tag), userhand1y, v.hy1);
    check($sformatf("%s_hand2x", tag), userhand2x, v.hx2);
    check($sformatf("%s_hand2y", tag), userhand2y, v.hy2);
    check($sformatf("%s_grab1", tag), usergrab1, v.g1);
    check($sformatf("%s_grab2", tag), usergrab2, v.g2);
    check($sformatf("%s_seen1", tag), seen1, v.s1);
    check($sformatf("%s_seen2", tag), seen2, v.s2);
    @(posedge clock_65mhz); #1;
    check($sformatf("%s_update_pulse_width", tag), update, 0);
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int lat, got;
    drive_frame(v);
    end_frame(lat, got);
    check_frame(tag, v, lat, got);
  endtask

  initial begin
    vec_t tbl[16];
    vec_t fa;
    int   lat, got, saw;

    //         glove1 x,y,w,h,fing  glove2 x,y,w,h,fing  oob  hand1    hand2    g1 g2 s1 s2 lat
    tbl[0]  = '{100,200,8,8,0,  500,300,10,10,40, 0,  103,203, 504,304, 0,0,1,1, 51};
    tbl[1]  = '{100,200,8,8,0,  500,300,10,10,40, 0,  103,203, 504,304, 0,0,1,1, 51};
    tbl[2]  = '{100,200,8,8,0,  500,300,10,10,40, 0,  103,203, 504,304, 1,0,1,1, 51};
    tbl[3]  = '{0,0,0,0,0,      500,300,10,10,40, 0,  103,203, 504,304, 1,0,0,1, 27};
    tbl[4]  = '{0,0,0,0,0,      500,300,10,10,40, 0,  103,203, 504,304, 1,0,0,1, 27};
    tbl[5]  = '{100,200,8,8,0,  500,300,10,10,40, 0,  103,203, 504,304, 1,0,1,1, 51};
    tbl[6]  = '{0,0,0,0,0,      500,300,10,10,40, 0,  103,203, 504,304, 1,0,0,1, 27};
    tbl[7]  = '{0,0,0,0,0,      500,300,10,10,40, 0,  103,203, 504,304, 1,0,0,1, 27};
    tbl[8]  = '{0,0,0,0,0,      500,300,10,10,40, 0,  103,203, 504,304, 0,0,0,1, 27};
    tbl[9]  = '{1023,400,1,64,0, 0,0,0,0,0,       0,  1023,431, 504,304, 0,0,1,0, 27};
    tbl[10] = '{1023,400,1,63,0, 500,300,10,10,31, 0, 1023,431, 504,304, 0,0,0,1, 27};
    tbl[11] = '{0,0,0,0,0,      500,300,10,10,31, 20, 1023,431, 504,304, 0,0,0,1, 27};
    tbl[12] = '{0,0,0,0,0,      500,300,10,10,31, 0,  1023,431, 504,304, 0,1,0,1, 27};
    tbl[13] = '{0,0,0,0,0,      500,300,10,10,32, 0,  1023,431, 504,304, 0,1,0,1, 27};
    tbl[14] = '{100,200,8,8,0,  500,300,10,10,0,  0,  103,203, 504,304, 0,1,1,1, 51};
    tbl[15] = '{0,0,0,0,0,      0,0,0,0,0,        20, 103,203, 504,304, 0,1,0,0, 3};

    reset = 1'b1;
    vsync = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clock_65mhz);
    #1 reset = 1'b0;
    @(posedge clock_65mhz); #1;
    check("reset_hand1x", userhand1x, 0);
    check("reset_hand1y", userhand1y, 0);
    check("reset_hand2x", userhand2x, 0);
    check("reset_hand2y", userhand2y, 0);
    check("reset_grab1", usergrab1, 0);
    check("reset_grab2", usergrab2, 0);
    check("reset_seen1", seen1, 0);
    check("reset_seen2", seen2, 0);
    check("reset_update", update, 0);

    for (int i = 0; i < 16; i++) apply_vec($sformatf("f%0d", i + 1), tbl[i]);

    // A second frame end arrives while dividing: it must not disturb the
    // snapshot, the result or the latency of the frame in progress.
    fa = '{200,100,8,8,0, 500,300,10,10,40, 0, 203,103, 504,304, 0,1,1,1, 51};
    drive_frame(fa);
    lat = 0; got = 0;
    vsync = 1'b0;
    for (int c = 1; c <= 200 && got == 0; c++) begin
      @(posedge clock_65mhz); #1;
      if (update) begin
        got = 1;
        lat = c;
      end else begin
        if (c == 4) vsync = 1'b1;
        if (c == 10) begin hcount = 11'd0; vcount = 10'd0; end
        if (c >= 11 && c <= 15) begin
          hcount = 11'(690 + c); vcount = 10'd20; palm1 = 1'b1; palm2 = 1'b1;
        end
        if (c == 16) idle_inputs();
        if (c == 20) vsync = 1'b0;
        if (c == 24) vsync = 1'b1;
      end
    end
    vsync = 1'b1;
    idle_inputs();
    check_frame("drop", fa, lat, got);

    // Reset ten cycles into DIV: outputs clear at once, no update follows.
    drive_frame(tbl[0]);
    vsync = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock_65mhz); #1;
      if (c == 4) vsync = 1'b1;
    end
    reset = 1'b1;
    #1;
    check("rst_div_hand1x", userhand1x, 0);
    check("rst_div_hand1y", userhand1y, 0);
    check("rst_div_hand2x", userhand2x, 0);
    check("rst_div_hand2y", userhand2y, 0);
    check("rst_div_grab2", usergrab2, 0);
    check("rst_div_seen1", seen1, 0);
    check("rst_div_seen2", seen2, 0);
    @(posedge clock_65mhz);
    @(posedge clock_65mhz); #1;
    reset = 1'b0;
    saw = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clock_65mhz); #1;
      if (update) saw = 1;
    end
    check("rst_div_no_update", saw, 0);
    apply_vec("post_rst", tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
